// File: rtl/usb_pkt_pkg.sv
// Shared types and constants for the USB DATA packet builder: FSM states, PIDs,
// writer data_select codes, CRC16 constants and the bit-order helper functions.
package usb_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CRC,
    ST_LOAD,
    ST_SEND
  } state_t;

  localparam logic [3:0]  PID_DATA0      = 4'b0011;
  localparam logic [3:0]  PID_DATA1      = 4'b1011;

  localparam logic [2:0]  DATA_SEL_IDLE  = 3'b000;
  localparam logic [2:0]  DATA_SEL_DATA0 = 3'b001;
  localparam logic [2:0]  DATA_SEL_DATA1 = 3'b010;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  localparam logic [7:0]  SYNC_PATTERN   = 8'b00000001;

  // PID field in transmit order: PID LSB first, then its complement check nibble.
  function automatic logic [7:0] pid_field(input logic [3:0] pid);
    return {pid[0], pid[1], pid[2], pid[3], ~pid[0], ~pid[1], ~pid[2], ~pid[3]};
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial USB CRC16 (poly 0x8005), one bit per enabled clock; clear loads the
// all-ones seed. Result is registered and valid the cycle after the last bit.
module usb_crc16_serial
  import usb_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[15] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_crc <= '0;
    end else if (i_clear) begin
      r_crc <= CRC16_INIT;
    end else if (i_enable) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/usb_packet_builder.sv
// Collects payload bytes, runs a serial CRC16 and presents a held DATA0/DATA1 packet
// to the writer until PACKET_BITS shift strobes are seen. Optional abort: USB_PKT_ABORT_EN.
module usb_packet_builder
  import usb_pkt_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 7,
  parameter int PACKET_BITS   = 8 + 8 + 8 * PAYLOAD_BYTES + 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   shift,
`ifdef USB_PKT_ABORT_EN
  input  logic                   abort,
`endif
  output logic [PACKET_BITS-1:0] packet_out,
  output logic                   ready,
  output logic [2:0]             data_select,
  output logic                   busy
);

  localparam int PAYLOAD_W = 8 * PAYLOAD_BYTES;
  localparam int BCNT_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam int SCNT_W    = $clog2(PACKET_BITS);

  state_t                 r_state;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [7:0]             r_cur_byte;
  logic [2:0]             r_bit_idx;
  logic [BCNT_W-1:0]      r_byte_cnt;
  logic [SCNT_W-1:0]      r_shift_cnt;
  logic                   r_toggle;
  logic                   r_byte_ready;
  logic                   r_ready;
  logic                   r_busy;
  logic [2:0]             r_data_select;
  logic [PACKET_BITS-1:0] r_packet;

  logic                   w_abort;
  logic                   w_crc_clear;
  logic                   w_crc_en;
  logic [15:0]            w_crc;

`ifdef USB_PKT_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_crc_clear = (r_state == ST_IDLE) && start;
  assign w_crc_en    = (r_state == ST_CRC) && !w_abort;

  usb_crc16_serial u_crc (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (w_crc_clear),
    .i_enable (w_crc_en),
    .i_bit    (r_cur_byte[r_bit_idx]),
    .o_crc    (w_crc)
  );

  assign byte_ready  = r_byte_ready;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign data_select = r_data_select;
  assign packet_out  = r_packet;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_payload     <= '0;
      r_cur_byte    <= '0;
      r_bit_idx     <= '0;
      r_byte_cnt    <= '0;
      r_shift_cnt   <= '0;
      r_toggle      <= 1'b0;
      r_byte_ready  <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_data_select <= DATA_SEL_IDLE;
      r_packet      <= '0;
    end else if (w_abort) begin
      // Toggle is deliberately left alone so the retried packet reuses the same PID.
      r_state       <= ST_IDLE;
      r_bit_idx     <= '0;
      r_byte_cnt    <= '0;
      r_shift_cnt   <= '0;
      r_byte_ready  <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_data_select <= DATA_SEL_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_COLLECT;
            r_byte_cnt   <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (byte_valid && r_byte_ready) begin
            // Shifting in from the bottom leaves byte 0 at the top after the last byte.
            r_payload    <= {r_payload[PAYLOAD_W-9:0], bit_rev8(byte_in)};
            r_cur_byte   <= byte_in;
            r_bit_idx    <= '0;
            r_byte_ready <= 1'b0;
            r_state      <= ST_CRC;
          end
        end
        ST_CRC: begin
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            if (r_byte_cnt == BCNT_W'(PAYLOAD_BYTES - 1)) begin
              r_byte_cnt <= '0;
              r_state    <= ST_LOAD;
            end else begin
              r_byte_cnt   <= r_byte_cnt + 1'b1;
              r_byte_ready <= 1'b1;
              r_state      <= ST_COLLECT;
            end
          end
        end
        ST_LOAD: begin
          r_packet      <= {SYNC_PATTERN, pid_field(r_toggle ? PID_DATA1 : PID_DATA0),
                            r_payload, ~w_crc};
          r_data_select <= r_toggle ? DATA_SEL_DATA1 : DATA_SEL_DATA0;
          r_shift_cnt   <= '0;
          r_ready       <= 1'b1;
          r_state       <= ST_SEND;
        end
        ST_SEND: begin
          if (shift) begin
            if (r_shift_cnt == SCNT_W'(PACKET_BITS - 1)) begin
              r_shift_cnt   <= '0;
              r_ready       <= 1'b0;
              r_data_select <= DATA_SEL_IDLE;
              r_toggle      <= ~r_toggle;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_shift_cnt <= r_shift_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_packet_builder.sv
// Directed bench for usb_packet_builder: expected packets are built from a CRC model
// and queued when a packet is started, then compared when ready rises.
module tb_usb_packet_builder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        shift = 1'b0;
  logic        byte_ready;
  logic [87:0] packet_out;
  logic        ready;
  logic [2:0]  data_select;
  logic        busy;
`ifdef USB_PKT_ABORT_EN
  logic        abort = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  pay [7];
  logic [90:0] sb_q [$];
  logic        exp_toggle = 1'b0;
  logic [87:0] exp_last = '0;

  always #5 clk = ~clk;

  usb_packet_builder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .shift       (shift),
`ifdef USB_PKT_ABORT_EN
    .abort       (abort),
`endif
    .packet_out  (packet_out),
    .ready       (ready),
    .data_select (data_select),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  task automatic push_expected();
    logic [15:0] crc;
    logic [55:0] body;
    logic [7:0]  rev;
    logic [7:0]  pid;
    logic [2:0]  ds;
    crc  = 16'hFFFF;
    body = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 8; j++) begin
        crc    = crc_step(crc, pay[i][j]);
        rev[7-j] = pay[i][j];
      end
      body = {body[47:0], rev};
    end
    pid = exp_toggle ? 8'b11010010 : 8'b11000011;
    ds  = exp_toggle ? 3'b010 : 3'b001;
    sb_q.push_back({ds, 8'h01, pid, body, ~crc});
  endtask

  task automatic run_packet(input int stall_at, input bit shift_noise);
    int   idx;
    int   cyc;
    int   prev_acc;
    int   stall_cnt;
    int   lat;
    bit   acc;
    logic [90:0] e;
    logic [15:0] res;
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; cyc = 0; prev_acc = -1; stall_cnt = 0;
    byte_in = pay[0];
    while (idx < 7 && cyc < 1000) begin
      if (shift_noise) shift = ~shift;
      if (idx == stall_at && stall_cnt < 20) begin
        byte_valid = 1'b0;
        stall_cnt++;
      end else begin
        byte_valid = 1'b1;
      end
      acc = byte_valid && byte_ready;
      tick();
      cyc++;
      if (acc) begin
        if (stall_at < 0 && prev_acc >= 0) check("accept_gap", cyc - prev_acc, 9);
        prev_acc = cyc;
        idx++;
        if (idx < 7) byte_in = pay[idx];
      end
    end
    if (idx < 7) check("accept_timeout", idx, 7);
    byte_valid = 1'b0;
    shift = 1'b0;
    check("byte_ready_after_last", byte_ready, 0);
    lat = 1;
    while (!ready && lat < 200) begin
      tick();
      lat++;
    end
    check("ready_latency", lat, 10);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      exp_last = e[87:0];
      check("packet", packet_out, e[87:0]);
      check("data_select", data_select, e[90:88]);
    end
    res = 16'hFFFF;
    for (int k = 71; k >= 0; k--) res = crc_step(res, packet_out[k]);
    check("crc_residual", res, 16'h800D);
  endtask

  task automatic send_packet(input bit start_noise);
    shift = 1'b1;
    for (int k = 1; k <= 87; k++) begin
      tick();
      start = start_noise && (k == 20);
    end
    start = 1'b0;
    check("ready_before_last_strobe", ready, 1);
    check("packet_held", packet_out, exp_last);
    tick();
    shift = 1'b0;
    check("ready_after_last_strobe", ready, 0);
    check("data_select_idle", data_select, 0);
    check("busy_idle", busy, 0);
    exp_toggle = ~exp_toggle;
  endtask

  task automatic reset_mid_crc();
    int idx;
    int cyc;
    bit acc;
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; cyc = 0;
    byte_valid = 1'b1;
    byte_in = pay[0];
    while (idx < 4 && cyc < 500) begin
      acc = byte_valid && byte_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        byte_in = pay[idx];
      end
    end
    byte_valid = 1'b0;
    repeat (3) tick();
    check("busy_in_crc", busy, 1);
    check("byte_ready_in_crc", byte_ready, 0);
    n_rst = 1'b0;
    #1;
    check("rst_byte_ready", byte_ready, 0);
    check("rst_ready", ready, 0);
    check("rst_packet_out", packet_out, 0);
    check("rst_data_select", data_select, 0);
    check("rst_busy", busy, 0);
    void'(sb_q.pop_back());
    exp_toggle = 1'b0;
    #2;
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (2) tick();
    check("reset_byte_ready", byte_ready, 0);
    check("reset_ready", ready, 0);
    check("reset_packet_out", packet_out, 0);
    check("reset_data_select", data_select, 0);
    check("reset_busy", busy, 0);
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) pay[i] = 8'(i);
    run_packet(-1, 1'b0);
    check("sync_field", packet_out[87:80], 8'h01);
    check("pid_data0", packet_out[79:72], 8'b11000011);
    check("ds_data0", data_select, 3'b001);
    send_packet(1'b0);

    run_packet(-1, 1'b0);
    check("pid_data1", packet_out[79:72], 8'b11010010);
    check("ds_data1", data_select, 3'b010);
    send_packet(1'b1);

    for (int i = 0; i < 7; i++) pay[i] = 8'($urandom_range(0, 255));
    run_packet(3, 1'b1);
    check("ds_toggle_back", data_select, 3'b001);
    send_packet(1'b0);

    for (int i = 0; i < 7; i++) pay[i] = 8'($urandom_range(0, 255));
    reset_mid_crc();
    for (int i = 0; i < 7; i++) pay[i] = 8'($urandom_range(0, 255));
    run_packet(-1, 1'b0);
    check("ds_after_reset", data_select, 3'b001);
    send_packet(1'b0);

`ifdef USB_PKT_ABORT_EN
    run_packet(-1, 1'b0);
    shift = 1'b1;
    repeat (40) tick();
    shift = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", ready, 0);
    check("abort_ds", data_select, 0);
    check("abort_busy", busy, 0);
    run_packet(-1, 1'b0);
    check("abort_same_pid", data_select, exp_toggle ? 3'b010 : 3'b001);
    send_packet(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
